// File: rtl/flipflop_pkg.sv
// flipflop_pkg
//   Constants shared by the flip-flop family (D, JK, T).
//   FF_RESET_BIT      : per-bit value a flip-flop takes on reset when no
//                       override is given.
//   FF_DEFAULT_WIDTH  : default number of bits in a flip-flop bank.
package flipflop_pkg;

    localparam logic        FF_RESET_BIT     = 1'b0;
    localparam int unsigned FF_DEFAULT_WIDTH = 1;

endpackage : flipflop_pkg

// File: rtl/t_flipflop_cell.sv
// t_flipflop_cell
//   One T flip-flop bit with asynchronous reset and synchronous load.
//   Priority: Res > Load > (En & T) toggle > hold.
//   Ports:
//     Clk  - rising-edge clock
//     Res  - asynchronous active-high reset, forces Q = RST_VAL
//     En   - toggle enable (gates T only)
//     T    - toggle request
//     Load - synchronous load, overrides toggling, independent of En
//     Din  - value stored when Load is high
//     Q    - registered state
module t_flipflop_cell
    import flipflop_pkg::*;
#(
    parameter logic RST_VAL = FF_RESET_BIT
) (
    input  logic Clk,
    input  logic Res,
    input  logic En,
    input  logic T,
    input  logic Load,
    input  logic Din,
    output logic Q
);

    always_ff @(posedge Clk or posedge Res) begin
        if (Res) begin
            Q <= RST_VAL;
        end else if (Load) begin
            Q <= Din;
        end else if (En && T) begin
            Q <= ~Q;
        end
    end

endmodule : t_flipflop_cell

// File: rtl/t_flipflop.sv
// t_flipflop
//   Bank of WIDTH independent T flip-flops sharing Clk, Res, En and Load.
//   Ports:
//     Clk  - rising-edge clock
//     Res  - asynchronous active-high reset, forces Q = RESET_VALUE
//     En   - toggle enable, shared by all bits
//     T    - per-bit toggle request
//     Load - synchronous parallel load, wins over toggling
//     Din  - parallel load value
//     Q    - registered state
//     Qn   - combinational complement of Q
module t_flipflop
    import flipflop_pkg::*;
#(
    parameter int unsigned             WIDTH       = FF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]        RESET_VALUE = {WIDTH{FF_RESET_BIT}}
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic             En,
    input  logic [WIDTH-1:0] T,
    input  logic             Load,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_flipflop_cell #(
            .RST_VAL (RESET_VALUE[i])
        ) u_cell (
            .Clk  (Clk),
            .Res  (Res),
            .En   (En),
            .T    (T[i]),
            .Load (Load),
            .Din  (Din[i]),
            .Q    (Q[i])
        );
    end

    assign Qn = ~Q;

endmodule : t_flipflop

// File: tb/tb_t_flipflop.sv
// tb_t_flipflop
//   Directed, table-driven check of the t_flipflop bank (WIDTH = 4), plus
//   hand-written sequences for asynchronous reset and multi-bit behaviour.
//   A second instance with a non-zero RESET_VALUE covers the reset pattern.
module tb_t_flipflop;

    logic       Clk = 1'b0;
    logic       Res;
    logic       En;
    logic [3:0] T;
    logic       Load;
    logic [3:0] Din;
    logic [3:0] Q,  Qn;
    logic [3:0] Q2, Qn2;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 Clk = ~Clk;

    t_flipflop #(
        .WIDTH       (4),
        .RESET_VALUE (4'b0000)
    ) dut (
        .Clk  (Clk),
        .Res  (Res),
        .En   (En),
        .T    (T),
        .Load (Load),
        .Din  (Din),
        .Q    (Q),
        .Qn   (Qn)
    );

    t_flipflop #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1001)
    ) dut_rv (
        .Clk  (Clk),
        .Res  (Res),
        .En   (En),
        .T    (T),
        .Load (Load),
        .Din  (Din),
        .Q    (Q2),
        .Qn   (Qn2)
    );

    typedef struct {
        logic       load;
        logic       en;
        logic [3:0] t;
        logic [3:0] din;
        logic [3:0] exp_q;
    } vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs just after an edge, wait for the next edge, sample 1 time unit later.
    task automatic step(input logic load, input logic en, input logic [3:0] t, input logic [3:0] din);
        Load = load;
        En   = en;
        T    = t;
        Din  = din;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[15];

        // Starting point for the table is Q = 0000 after reset.
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111}; // load 1s, no enable
        vecs[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000}; // load 0s
        vecs[2]  = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111}; // back to 1s
        vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1111}; // T without En: hold
        vecs[4]  = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b1111};
        vecs[5]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111}; // En without T: hold
        vecs[6]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111};
        vecs[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000}; // toggle run 0,1,0,1
        vecs[8]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1111};
        vecs[9]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000};
        vecs[10] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b1111};
        vecs[11] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000}; // load beats toggle
        vecs[12] = '{1'b1, 1'b1, 4'b1111, 4'b0101, 4'b0101}; // load beats toggle
        vecs[13] = '{1'b0, 1'b1, 4'b0011, 4'b0000, 4'b0110}; // per-bit toggle
        vecs[14] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0110}; // idle: hold

        // Initial reset with other inputs idle.
        Res = 1'b1; Load = 1'b0; En = 1'b0; T = '0; Din = '0;
        #1;
        check("reset_q",     Q,   4'b0000);
        check("reset_qn",    Qn,  4'b1111);
        check("reset_rv_q",  Q2,  4'b1001);
        @(posedge Clk);
        #1;
        Res = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].load, vecs[i].en, vecs[i].t, vecs[i].din);
            check($sformatf("vec%0d_q", i),  Q,  vecs[i].exp_q);
            check($sformatf("vec%0d_qn", i), Qn, ~vecs[i].exp_q);
        end

        // Asynchronous reset mid-cycle while a load of 1s is pending.
        Load = 1'b1; Din = 4'b1111; En = 1'b1; T = 4'b1111;
        @(posedge Clk);
        #1;
        check("preload_q", Q, 4'b1111);
        #2;
        Res = 1'b1;
        #1;  // still before the next rising edge
        check("async_reset_q",    Q,  4'b0000);
        check("async_reset_qn",   Qn, 4'b1111);
        check("async_reset_rv_q", Q2, 4'b1001);
        for (int e = 0; e < 2; e++) begin
            @(posedge Clk);
            #1;
            check($sformatf("reset_hold%0d_q", e),    Q,  4'b0000);
            check($sformatf("reset_hold%0d_rv_q", e), Q2, 4'b1001);
        end
        Res = 1'b0;

        // Multi-bit toggle from reset, then parallel load.
        step(1'b0, 1'b1, 4'b1010, 4'b0000);
        check("mb_toggle_q",    Q,  4'b1010);
        check("mb_toggle_rv_q", Q2, 4'b0011);
        step(1'b1, 1'b0, 4'b0000, 4'b0110);
        check("mb_load_q",     Q,   4'b0110);
        check("mb_load_qn",    Qn,  4'b1001);
        check("mb_load_rv_q",  Q2,  4'b0110);

        // Inputs wiggled between edges but idle at the edge: hold.
        Load = 1'b0; En = 1'b0; T = '0;
        #2;
        Load = 1'b1; Din = 4'b1111; En = 1'b1; T = 4'b1111;
        #2;
        Load = 1'b0; En = 1'b0; T = '0;
        @(posedge Clk);
        #1;
        check("between_edges_q", Q, 4'b0110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_t_flipflop
